// File: rtl/array_result_drain.sv
// Result drain below the systolic array: ping-pong row buffer
// serialized one lane per beat onto a valid/ready stream.
module array_result_drain #(
   parameter  int DATA_WIDTH = 8,
   parameter  int BLOCK_SIZE = 4,
   parameter  int ARRAY_SIZE = 4,
   localparam int LANES      = BLOCK_SIZE * ARRAY_SIZE,
   localparam int LW         = $clog2(LANES),
   localparam int WW         = 4 * DATA_WIDTH
) (
   input  logic          Clk,
   input  logic          rst,
   input  logic [WW-1:0] Array_Output [LANES],
   input  logic          capture_valid,
   input  logic          relu_en,
   output logic          capture_ready,
   output logic [WW-1:0] out_data,
   output logic [LW-1:0] out_lane,
   output logic          out_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          overflow
);

   logic [WW-1:0] bank_q [2][LANES];
   logic [1:0]    full_q, full_d;
   logic [1:0]    relu_q, relu_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [LW-1:0] lane_cnt_q, lane_cnt_d;
   logic          overflow_q, overflow_d;

   logic          do_cap;
   logic          do_drop;
   logic          do_beat;
   logic          at_last;
   logic [WW-1:0] rd_word;

   assign capture_ready = !full_q[wr_bank_q];
   assign do_cap        = capture_valid && capture_ready;
   assign do_drop       = capture_valid && !capture_ready;
   assign out_valid     = full_q[rd_bank_q];
   assign at_last       = (lane_cnt_q == LW'(LANES - 1));
   assign do_beat       = out_valid && out_ready;
   assign out_lane      = lane_cnt_q;
   assign out_last      = out_valid && at_last;
   assign busy          = full_q[0] | full_q[1];
   assign overflow      = overflow_q;

   // Read mux with optional clamp of negative words to zero.
   always_comb begin
      rd_word  = bank_q[rd_bank_q][lane_cnt_q];
      out_data = rd_word;
      if (relu_q[rd_bank_q] && rd_word[WW-1]) begin
         out_data = '0;
      end
   end

   // Next state for flags and pointers; capture and last beat
   // never hit the same bank because a full bank blocks capture.
   always_comb begin
      full_d     = full_q;
      relu_d     = relu_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      lane_cnt_d = lane_cnt_q;
      overflow_d = overflow_q | do_drop;
      if (do_cap) begin
         full_d[wr_bank_q] = 1'b1;
         relu_d[wr_bank_q] = relu_en;
         wr_bank_d         = !wr_bank_q;
      end
      if (do_beat) begin
         if (at_last) begin
            lane_cnt_d        = '0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end else begin
            lane_cnt_d = lane_cnt_q + LW'(1);
         end
      end
   end

   // Control registers.
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         full_q     <= '0;
         relu_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         lane_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         relu_q     <= relu_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         lane_cnt_q <= lane_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Row storage: whole row written into the write bank at once.
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < LANES; l++) begin
               bank_q[b][l] <= '0;
            end
         end
      end else if (do_cap) begin
         for (int l = 0; l < LANES; l++) begin
            bank_q[wr_bank_q][l] <= Array_Output[l];
         end
      end
   end

endmodule
